// File: rtl/pipe_reg_chain.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_reg_chain
//  Brief    : DEPTH-stage WIDTH-bit pipeline register chain with per-stage
//             valid bits, valid/ready flow control, bubble collapsing and
//             synchronous flush.
//  Options  : PIPE_STALL_STATS_EN adds a saturating 16-bit output stall
//             counter port (stall_cnt).
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_reg_chain #(
    parameter int               WIDTH     = 32,
    parameter int               DEPTH     = 3,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data,
    input  logic                         flush,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
`ifdef PIPE_STALL_STATS_EN
    ,
    output logic [15:0]                  stall_cnt
`endif
);

    localparam int OCC_W = $clog2(DEPTH+1);

    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_d;
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] data_d [DEPTH];
    logic [DEPTH-1:0] adv;
    // room[k]: a payload moving into stage k this cycle has a place to go.
    // room[DEPTH] is the downstream consumer.
    logic [DEPTH:0]   room;
    logic             in_accept;

    // Ready chain from the output back to the input; flush freezes all movement.
    always_comb begin
        room        = '0;
        adv         = '0;
        room[DEPTH] = out_ready & ~flush;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            adv[k]  = valid_q[k] & room[k+1] & ~flush;
            // An empty stage always accepts, which collapses bubbles.
            room[k] = room[k+1] | ~valid_q[k];
        end
        in_ready  = ~flush & room[0];
        in_accept = in_valid & in_ready;
    end

    // Next-state for every stage: load from predecessor, hold when stalled.
    always_comb begin
        valid_d = '0;
        for (int k = 0; k < DEPTH; k++) begin
            data_d[k] = data_q[k];
        end
        valid_d[0] = ~flush & (in_accept | (valid_q[0] & ~adv[0]));
        if (in_accept) begin
            data_d[0] = in_data;
        end
        for (int k = 1; k < DEPTH; k++) begin
            valid_d[k] = ~flush & (adv[k-1] | (valid_q[k] & ~adv[k]));
            if (adv[k-1]) begin
                data_d[k] = data_q[k-1];
            end
        end
    end

    // Stage registers; reset discards all in-flight payloads immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                data_q[k] <= RESET_VAL;
            end
        end else begin
            valid_q <= valid_d;
            for (int k = 0; k < DEPTH; k++) begin
                data_q[k] <= data_d[k];
            end
        end
    end

    // Occupancy is the popcount of the registered stage valid bits.
    always_comb begin
        occupancy = '0;
        for (int k = 0; k < DEPTH; k++) begin
            occupancy = occupancy + OCC_W'(valid_q[k]);
        end
    end

    assign out_valid = valid_q[DEPTH-1] & ~flush;
    assign out_data  = data_q[DEPTH-1];

`ifdef PIPE_STALL_STATS_EN
    logic [15:0] stall_cnt_q;
    logic [15:0] stall_cnt_d;

    // Count output stall cycles, saturating; flush clears and wins over counting.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (flush) begin
            stall_cnt_d = '0;
        end else if (out_valid && !out_ready && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_reg_chain.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_reg_chain
//  Brief    : Self-checking bench for pipe_reg_chain. The reference model is
//             a queue of in-flight payloads with their ages; a payload sits at
//             stage min(age, DEPTH-1-index), so the head is visible once its
//             age reaches DEPTH-1. The chain accepts when not full or when the
//             head is being consumed.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_reg_chain;

    localparam int          WIDTH = 32;
    localparam int          DEPTH = 3;
    localparam int          OCC_W = $clog2(DEPTH+1);
    localparam logic [31:0] RVAL  = 32'h5A5A_0F0F;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  in_data;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  out_data;
    logic              flush;
    logic [OCC_W-1:0]  occupancy;
`ifdef PIPE_STALL_STATS_EN
    logic [15:0]       stall_cnt;
`endif

    always #5 clk = ~clk;

    pipe_reg_chain #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .RESET_VAL (RVAL)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .flush     (flush),
        .occupancy (occupancy)
`ifdef PIPE_STALL_STATS_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    // Reference model state
    logic [31:0] m_data [$];
    int          m_age  [$];
    logic [31:0] m_last;
    int          m_stall;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic exp_ov(input logic fl);
        return !fl && (m_data.size() > 0) && (m_age[0] >= DEPTH - 1);
    endfunction

    function automatic logic exp_ir(input logic fl, input logic ordy);
        return !fl && ((m_data.size() < DEPTH) || (exp_ov(fl) && ordy));
    endfunction

    task automatic model_clear();
        m_data.delete();
        m_age.delete();
    endtask

    // One clock cycle: drive, check against model, then advance model at the edge.
    task automatic step(input logic iv, input logic [31:0] d, input logic ordy, input logic fl);
        logic ev;
        logic er;
        @(negedge clk);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        #1;
        ev = exp_ov(fl);
        er = exp_ir(fl, ordy);
        chk("in_ready",  32'(in_ready),  32'(er));
        chk("out_valid", 32'(out_valid), 32'(ev));
        chk("occupancy", 32'(occupancy), 32'(m_data.size()));
        chk("out_data",  out_data,       m_last);
`ifdef PIPE_STALL_STATS_EN
        chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
`endif
        @(posedge clk);
        if (fl) begin
            model_clear();
            m_stall = 0;
        end else begin
            if (ev && !ordy && m_stall < 65535) m_stall++;
            if (ev && ordy) begin
                void'(m_data.pop_front());
                void'(m_age.pop_front());
            end
            foreach (m_age[i]) m_age[i]++;
            if (iv && er) begin
                m_data.push_back(d);
                m_age.push_back(0);
            end
        end
        if (m_data.size() > 0 && m_age[0] >= DEPTH - 1) m_last = m_data[0];
    endtask

    // Asynchronous reset: effects checked before any clock edge occurs.
    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        #1;
        model_clear();
        m_last  = RVAL;
        m_stall = 0;
        chk("rst_occupancy", 32'(occupancy), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  out_data,       RVAL);
`ifdef PIPE_STALL_STATS_EN
        chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        flush     = 1'b0;
        m_last    = RVAL;
        m_stall   = 0;
        #1;
        rst = 1'b1;

        do_reset();

        // Single payload latency
        step(1'b1, 32'hA5A5_0001, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, $urandom, 1'b1, 1'b0);

        // Back-to-back stream
        for (int i = 0; i < 8; i++) step(1'b1, 32'(i), 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 32'd0, 1'b1, 1'b0);

        // Fill while stalled, fourth rejected, then drain with pass-through
        for (int i = 0; i < 4; i++) step(1'b1, 32'(i), 1'b0, 1'b0);
        step(1'b1, 32'd3, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 32'd0, 1'b1, 1'b0);

        // Bubble collapse behind a stalled output
        step(1'b1, 32'd10, 1'b0, 1'b0);
        step(1'b0, 32'd0,  1'b0, 1'b0);
        step(1'b1, 32'd11, 1'b0, 1'b0);
        step(1'b0, 32'd0,  1'b0, 1'b0);
        step(1'b0, 32'd0,  1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 32'd0, 1'b1, 1'b0);

        // Flush dominating in_valid/out_ready, then reset mid-stream
        step(1'b1, 32'd20, 1'b0, 1'b0);
        step(1'b1, 32'd21, 1'b0, 1'b0);
        step(1'b1, 32'd22, 1'b1, 1'b1);
        step(1'b0, 32'd0,  1'b1, 1'b0);
        step(1'b1, 32'd30, 1'b0, 1'b0);
        step(1'b1, 32'd31, 1'b0, 1'b0);
        do_reset();
        step(1'b0, 32'd0, 1'b1, 1'b0);

`ifdef PIPE_STALL_STATS_EN
        // Stall counting, clear on flush, saturation
        step(1'b1, 32'd40, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH - 1 + 5; i++) step(1'b0, 32'd0, 1'b0, 1'b0);
        chk("stall_after_5", 32'(stall_cnt), 32'd5);
        step(1'b0, 32'd0, 1'b0, 1'b1);
        step(1'b1, 32'd41, 1'b0, 1'b0);
        for (int i = 0; i < 70000; i++) step(1'b0, 32'd0, 1'b0, 1'b0);
        chk("stall_saturated", 32'(stall_cnt), 32'h0000_FFFF);
        step(1'b0, 32'd0, 1'b0, 1'b1);
        step(1'b0, 32'd0, 1'b1, 1'b0);
`endif

        // Randomized traffic with occasional flush and reset
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                step(1'($urandom_range(0, 1)), $urandom,
                     ($urandom_range(0, 3) != 0),
                     ($urandom_range(0, 39) == 0));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
